// File: rtl/wb_write_arbiter_pkg.sv
// wb_write_arbiter_pkg
//   Shared constants and types for the register-file writeback arbiter.
//   Provides the default geometry (data width, register address width,
//   register count, MDU queue depth), the register-zero address and the
//   enum naming which source owns the write port in a given cycle.
package wb_write_arbiter_pkg;

  localparam int WIDTH_DEF             = 32;
  localparam int REG_ADDRESS_WIDTH_DEF = 5;
  localparam int NO_OF_REG_DEF         = 32;
  localparam int DEPTH_DEF             = 4;
  localparam logic [REG_ADDRESS_WIDTH_DEF-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    SRC_NONE  = 2'd0,
    SRC_PIPE  = 2'd1,
    SRC_QUEUE = 2'd2,
    SRC_MDU   = 2'd3
  } wb_src_e;

endpackage

// File: rtl/wb_write_arbiter_if.sv
// wb_write_arbiter_if
//   Bundles the writeback sources (pipeline, MDU valid/ready handshake) and
//   the register-file write port plus queue status.
//   modport slave  : the arbiter (consumes pipe/MDU, drives WE3/A3/WD3,
//                    mdu_ready, q_count, pend_mask)
//   modport master : the environment (WB stage, MDU, register file, hazard unit)
interface wb_write_arbiter_if
  import wb_write_arbiter_pkg::*;
#(
  parameter int WIDTH             = WIDTH_DEF,
  parameter int REG_ADDRESS_WIDTH = REG_ADDRESS_WIDTH_DEF,
  parameter int NO_OF_REG         = NO_OF_REG_DEF,
  parameter int DEPTH             = DEPTH_DEF
);
  logic                         pipe_we;
  logic [REG_ADDRESS_WIDTH-1:0] pipe_addr;
  logic [WIDTH-1:0]             pipe_data;
  logic                         mdu_valid;
  logic                         mdu_ready;
  logic [REG_ADDRESS_WIDTH-1:0] mdu_addr;
  logic [WIDTH-1:0]             mdu_data;
  logic                         WE3;
  logic [REG_ADDRESS_WIDTH-1:0] A3;
  logic [WIDTH-1:0]             WD3;
  logic [$clog2(DEPTH):0]       q_count;
  logic [NO_OF_REG-1:0]         pend_mask;

  modport slave (
    input  pipe_we, pipe_addr, pipe_data, mdu_valid, mdu_addr, mdu_data,
    output mdu_ready, WE3, A3, WD3, q_count, pend_mask
  );

  modport master (
    output pipe_we, pipe_addr, pipe_data, mdu_valid, mdu_addr, mdu_data,
    input  mdu_ready, WE3, A3, WD3, q_count, pend_mask
  );
endinterface

// File: rtl/wb_write_arbiter_fifo.sv
// wb_fifo
//   DEPTH-entry circular buffer of queued MDU writes. Each entry carries a
//   valid bit (occupied) and a live bit (still allowed to write). A kill
//   request clears the live bit of every occupied entry whose address
//   matches. Optional macro WB_PEND_MASK_EN builds pend_mask from the live
//   entries; otherwise pend_mask is tied to 0.
//   Ports: clk, rst_n (sync, active low), push/push_addr/push_data,
//   pop, kill_en/kill_addr, head_live/head_addr/head_data, count, pend_mask.
module wb_fifo #(
  parameter int WIDTH = 32,
  parameter int AW    = 5,
  parameter int NREG  = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [AW-1:0]            push_addr,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     kill_en,
  input  logic [AW-1:0]            kill_addr,
  output logic                     head_live,
  output logic [AW-1:0]            head_addr,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic [NREG-1:0]          pend_mask
);
  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0] valid_q, live_q;
  logic [AW-1:0]    addr_q [DEPTH];
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [PW-1:0]    head_q, tail_q;
  logic [PW:0]      count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      live_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill_en && valid_q[i] && (addr_q[i] == kill_addr))
          live_q[i] <= 1'b0;
      end
      // push and pop never target the same slot: that needs count 0 or DEPTH
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        live_q[head_q]  <= 1'b0;
        head_q          <= head_q + PW'(1);
      end
      if (push) begin
        valid_q[tail_q] <= 1'b1;
        live_q[tail_q]  <= 1'b1;
        tail_q          <= tail_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= push_addr;
      data_q[tail_q] <= push_data;
    end
  end

  assign head_live = live_q[head_q];
  assign head_addr = addr_q[head_q];
  assign head_data = data_q[head_q];
  assign count     = count_q;

`ifdef WB_PEND_MASK_EN
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && live_q[i] && (addr_q[i] != '0))
        pend_mask[addr_q[i]] = 1'b1;
    end
  end
`else
  assign pend_mask = '0;
`endif

endmodule

// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter
//   Sole driver of the register-file write port. Each cycle the pipeline
//   writeback wins, then the head of the MDU queue, then a direct MDU
//   result when the queue is empty. MDU results that lose are queued;
//   a pipeline write kills older queued writes to the same register and
//   drops a same-cycle MDU result to that register. Writes to register 0
//   are suppressed. Optional macro WB_PEND_MASK_EN enables pend_mask.
//   Ports: clk, rst_n (sync, active low), bus (wb_write_arbiter_if.slave).
module wb_write_arbiter
  import wb_write_arbiter_pkg::*;
#(
  parameter int WIDTH             = WIDTH_DEF,
  parameter int REG_ADDRESS_WIDTH = REG_ADDRESS_WIDTH_DEF,
  parameter int NO_OF_REG         = NO_OF_REG_DEF,
  parameter int DEPTH             = DEPTH_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  wb_write_arbiter_if.slave   bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                         head_live;
  logic [REG_ADDRESS_WIDTH-1:0] head_addr;
  logic [WIDTH-1:0]             head_data;
  logic [CW-1:0]                count;
  logic [NO_OF_REG-1:0]         fifo_pend;
  logic                         ready, xfer, push, pop;
  wb_src_e                      src;
  logic                         we;
  logic [REG_ADDRESS_WIDTH-1:0] waddr;
  logic [WIDTH-1:0]             wdata;

  // ready depends only on registered occupancy, never on a same-cycle pop
  assign ready = rst_n && (count != CW'(DEPTH));
  assign xfer  = bus.mdu_valid && ready;

  always_comb begin
    src = SRC_NONE;
    if (bus.pipe_we)        src = SRC_PIPE;
    else if (count != '0)   src = SRC_QUEUE;
    else if (xfer)          src = SRC_MDU;
  end

  always_comb begin
    push  = 1'b0;
    pop   = 1'b0;
    we    = 1'b0;
    waddr = '0;
    wdata = '0;
    case (src)
      SRC_PIPE: begin
        we    = 1'b1;
        waddr = bus.pipe_addr;
        wdata = bus.pipe_data;
        // an MDU result to the same register is older than this write
        push  = xfer && (bus.mdu_addr != bus.pipe_addr);
      end
      SRC_QUEUE: begin
        pop   = 1'b1;
        we    = head_live;
        waddr = head_addr;
        wdata = head_data;
        push  = xfer;
      end
      SRC_MDU: begin
        we    = 1'b1;
        waddr = bus.mdu_addr;
        wdata = bus.mdu_data;
      end
      default: ;
    endcase
    if (waddr == '0) we = 1'b0;
    if (!rst_n) begin
      we    = 1'b0;
      waddr = '0;
      wdata = '0;
    end
  end

  wb_fifo #(
    .WIDTH (WIDTH),
    .AW    (REG_ADDRESS_WIDTH),
    .NREG  (NO_OF_REG),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_addr (bus.mdu_addr),
    .push_data (bus.mdu_data),
    .pop       (pop),
    .kill_en   (bus.pipe_we),
    .kill_addr (bus.pipe_addr),
    .head_live (head_live),
    .head_addr (head_addr),
    .head_data (head_data),
    .count     (count),
    .pend_mask (fifo_pend)
  );

  assign bus.mdu_ready = ready;
  assign bus.WE3       = we;
  assign bus.A3        = waddr;
  assign bus.WD3       = wdata;
  assign bus.q_count   = count;
  assign bus.pend_mask = rst_n ? fifo_pend : '0;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// tb_wb_write_arbiter
//   Directed scenarios plus a randomized run checked against a queue-based
//   reference model of the writeback arbitration rules.
module tb_wb_write_arbiter;
  localparam int DEPTH = 4;
`ifdef WB_PEND_MASK_EN
  localparam bit PEND_EN = 1'b1;
`else
  localparam bit PEND_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int checks = 0;
  int errors = 0;
  logic [31:0] rf [32];

  typedef struct {
    bit          live;
    logic [4:0]  addr;
    logic [31:0] data;
  } ent_t;
  ent_t mq[$];

  wb_write_arbiter_if #(.WIDTH(32), .REG_ADDRESS_WIDTH(5), .NO_OF_REG(32), .DEPTH(DEPTH)) bus ();

  wb_write_arbiter #(.WIDTH(32), .REG_ADDRESS_WIDTH(5), .NO_OF_REG(32), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (bus.WE3) rf[bus.A3] <= bus.WD3;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit pwe, input logic [4:0] pa, input logic [31:0] pd,
                       input bit mv, input logic [4:0] ma, input logic [31:0] md);
    bus.pipe_we = pwe; bus.pipe_addr = pa; bus.pipe_data = pd;
    bus.mdu_valid = mv; bus.mdu_addr = ma; bus.mdu_data = md;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1, 5'd4, 32'h1234, 1, 5'd6, 32'h55);
    tick();
    tick();
    checks++; if (bus.WE3 !== 1'b0) begin errors++; $display("FAIL reset_we3: got %b expected 0", bus.WE3); end
    checks++; if (bus.A3 !== 5'd0) begin errors++; $display("FAIL reset_a3: got %0d expected 0", bus.A3); end
    checks++; if (bus.WD3 !== 32'h0) begin errors++; $display("FAIL reset_wd3: got %h expected 0", bus.WD3); end
    checks++; if (bus.mdu_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", bus.mdu_ready); end
    checks++; if (bus.q_count !== 3'd0) begin errors++; $display("FAIL reset_qcount: got %0d expected 0", bus.q_count); end
    checks++; if (bus.pend_mask !== 32'h0) begin errors++; $display("FAIL reset_pend: got %h expected 0", bus.pend_mask); end
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_direct_mdu();
    do_reset();
    drive(0, 0, 0, 1, 5'd5, 32'hDEADBEEF);
    #1;
    checks++; if (bus.mdu_ready !== 1'b1) begin errors++; $display("FAIL direct_ready: got %b expected 1", bus.mdu_ready); end
    checks++; if (bus.WE3 !== 1'b1) begin errors++; $display("FAIL direct_we3: got %b expected 1", bus.WE3); end
    checks++; if (bus.A3 !== 5'd5) begin errors++; $display("FAIL direct_a3: got %0d expected 5", bus.A3); end
    checks++; if (bus.WD3 !== 32'hDEADBEEF) begin errors++; $display("FAIL direct_wd3: got %h expected deadbeef", bus.WD3); end
    tick();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    checks++; if (bus.q_count !== 3'd0) begin errors++; $display("FAIL direct_qcount: got %0d expected 0", bus.q_count); end
  endtask

  task automatic test_collision();
    do_reset();
    drive(1, 5'd3, 32'h11, 1, 5'd7, 32'h22);
    #1;
    checks++; if (bus.WE3 !== 1'b1 || bus.A3 !== 5'd3 || bus.WD3 !== 32'h11) begin errors++;
      $display("FAIL coll_pipe: got we=%b a=%0d d=%h expected we=1 a=3 d=11", bus.WE3, bus.A3, bus.WD3); end
    tick();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    checks++; if (bus.q_count !== 3'd1) begin errors++; $display("FAIL coll_qcount: got %0d expected 1", bus.q_count); end
    checks++; if (bus.pend_mask !== (PEND_EN ? 32'h80 : 32'h0)) begin errors++;
      $display("FAIL coll_pend: got %h expected %h", bus.pend_mask, PEND_EN ? 32'h80 : 32'h0); end
    checks++; if (bus.WE3 !== 1'b1 || bus.A3 !== 5'd7 || bus.WD3 !== 32'h22) begin errors++;
      $display("FAIL coll_pop: got we=%b a=%0d d=%h expected we=1 a=7 d=22", bus.WE3, bus.A3, bus.WD3); end
    tick();
    checks++; if (bus.q_count !== 3'd0) begin errors++; $display("FAIL coll_drained: got %0d expected 0", bus.q_count); end
    checks++; if (bus.pend_mask !== 32'h0) begin errors++; $display("FAIL coll_pend_clr: got %h expected 0", bus.pend_mask); end
    checks++; if (bus.WE3 !== 1'b0) begin errors++; $display("FAIL coll_idle_we3: got %b expected 0", bus.WE3); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, 5'd1, 32'h0, 1, 5'(10 + i), 32'h100 + i);
      #1;
      checks++; if (bus.mdu_ready !== 1'b1) begin errors++; $display("FAIL full_fill_ready%0d: got %b expected 1", i, bus.mdu_ready); end
      tick();
    end
    drive(1, 5'd1, 32'h0, 1, 5'd14, 32'h104);
    #1;
    checks++; if (bus.q_count !== 3'd4) begin errors++; $display("FAIL full_qcount: got %0d expected 4", bus.q_count); end
    checks++; if (bus.mdu_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b expected 0", bus.mdu_ready); end
    tick();
    checks++; if (bus.q_count !== 3'd4) begin errors++; $display("FAIL full_stall_qcount: got %0d expected 4", bus.q_count); end
    bus.pipe_we = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (bus.WE3 !== 1'b1 || bus.A3 !== 5'(10 + i) || bus.WD3 !== 32'h100 + i) begin errors++;
        $display("FAIL full_drain%0d: got we=%b a=%0d d=%h expected we=1 a=%0d d=%h", i, bus.WE3, bus.A3, bus.WD3, 10 + i, 32'h100 + i); end
      if (i == 0) begin
        checks++; if (bus.mdu_ready !== 1'b0) begin errors++; $display("FAIL full_pop_ready: got %b expected 0", bus.mdu_ready); end
      end
      if (i == 1) begin
        checks++; if (bus.mdu_ready !== 1'b1) begin errors++; $display("FAIL full_reopen_ready: got %b expected 1", bus.mdu_ready); end
      end
      tick();
      if (i == 1) bus.mdu_valid = 1'b0;
    end
    checks++; if (bus.q_count !== 3'd0) begin errors++; $display("FAIL full_empty: got %0d expected 0", bus.q_count); end
  endtask

  task automatic test_kill();
    do_reset();
    drive(1, 5'd2, 32'h5, 1, 5'd9, 32'hAA);
    tick();
    drive(1, 5'd9, 32'hBB, 0, 0, 0);
    #1;
    checks++; if (bus.WE3 !== 1'b1 || bus.A3 !== 5'd9 || bus.WD3 !== 32'hBB) begin errors++;
      $display("FAIL kill_pipe: got we=%b a=%0d d=%h expected we=1 a=9 d=bb", bus.WE3, bus.A3, bus.WD3); end
    checks++; if (bus.pend_mask !== (PEND_EN ? 32'h200 : 32'h0)) begin errors++;
      $display("FAIL kill_pend_before: got %h expected %h", bus.pend_mask, PEND_EN ? 32'h200 : 32'h0); end
    tick();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    checks++; if (bus.WE3 !== 1'b0) begin errors++; $display("FAIL kill_silent_pop: got %b expected 0", bus.WE3); end
    checks++; if (bus.q_count !== 3'd1) begin errors++; $display("FAIL kill_qcount: got %0d expected 1", bus.q_count); end
    checks++; if (bus.pend_mask !== 32'h0) begin errors++; $display("FAIL kill_pend_after: got %h expected 0", bus.pend_mask); end
    tick();
    checks++; if (bus.q_count !== 3'd0) begin errors++; $display("FAIL kill_drained: got %0d expected 0", bus.q_count); end
    checks++; if (rf[9] !== 32'hBB) begin errors++; $display("FAIL kill_reg9: got %h expected bb", rf[9]); end
    drive(1, 5'd6, 32'h1, 1, 5'd6, 32'h2);
    #1;
    checks++; if (bus.mdu_ready !== 1'b1) begin errors++; $display("FAIL drop_ready: got %b expected 1", bus.mdu_ready); end
    tick();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    checks++; if (bus.q_count !== 3'd0) begin errors++; $display("FAIL drop_qcount: got %0d expected 0", bus.q_count); end
    checks++; if (bus.WE3 !== 1'b0) begin errors++; $display("FAIL drop_we3: got %b expected 0", bus.WE3); end
  endtask

  task automatic test_zero_reg();
    do_reset();
    drive(0, 0, 0, 1, 5'd0, 32'h77);
    #1;
    checks++; if (bus.WE3 !== 1'b0) begin errors++; $display("FAIL zero_direct_we3: got %b expected 0", bus.WE3); end
    checks++; if (bus.mdu_ready !== 1'b1) begin errors++; $display("FAIL zero_ready: got %b expected 1", bus.mdu_ready); end
    tick();
    drive(1, 5'd3, 32'h33, 1, 5'd0, 32'h44);
    #1;
    checks++; if (bus.q_count !== 3'd0) begin errors++; $display("FAIL zero_direct_qcount: got %0d expected 0", bus.q_count); end
    tick();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    checks++; if (bus.q_count !== 3'd1) begin errors++; $display("FAIL zero_queued_qcount: got %0d expected 1", bus.q_count); end
    checks++; if (bus.pend_mask !== 32'h0) begin errors++; $display("FAIL zero_pend: got %h expected 0", bus.pend_mask); end
    checks++; if (bus.WE3 !== 1'b0) begin errors++; $display("FAIL zero_pop_we3: got %b expected 0", bus.WE3); end
    tick();
    drive(1, 5'd0, 32'h99, 0, 0, 0);
    #1;
    checks++; if (bus.q_count !== 3'd0) begin errors++; $display("FAIL zero_drained: got %0d expected 0", bus.q_count); end
    checks++; if (bus.WE3 !== 1'b0) begin errors++; $display("FAIL zero_pipe_we3: got %b expected 0", bus.WE3); end
    tick();
  endtask

  task automatic test_random();
    bit          e_ready, xfer, e_we;
    logic [4:0]  e_a;
    logic [31:0] e_d, e_pend;
    int          e_cnt;
    ent_t        ent;
    do_reset();
    mq.delete();
    for (int c = 0; c < 800; c++) begin
      rst_n = ($urandom_range(0, 59) != 0);
      drive($urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
            ($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), $urandom);
      #1;
      if (!rst_n) begin
        checks++; if (bus.WE3 !== 1'b0 || bus.A3 !== 5'd0 || bus.WD3 !== 32'h0) begin errors++;
          $display("FAIL rnd_reset_port c%0d: got we=%b a=%0d d=%h expected all 0", c, bus.WE3, bus.A3, bus.WD3); end
        checks++; if (bus.mdu_ready !== 1'b0 || bus.pend_mask !== 32'h0) begin errors++;
          $display("FAIL rnd_reset_status c%0d: got ready=%b pend=%h expected 0", c, bus.mdu_ready, bus.pend_mask); end
        mq.delete();
      end else begin
        e_cnt   = mq.size();
        e_ready = (e_cnt < DEPTH);
        xfer    = bus.mdu_valid && e_ready;
        e_pend  = '0;
        foreach (mq[i]) if (mq[i].live && mq[i].addr != 0) e_pend[mq[i].addr] = 1'b1;
        if (!PEND_EN) e_pend = '0;
        e_we = 1'b0; e_a = '0; e_d = '0;
        if (bus.pipe_we) begin
          e_we = (bus.pipe_addr != 0); e_a = bus.pipe_addr; e_d = bus.pipe_data;
          foreach (mq[i]) if (mq[i].addr == bus.pipe_addr) mq[i].live = 1'b0;
          if (xfer && bus.mdu_addr != bus.pipe_addr) mq.push_back('{1'b1, bus.mdu_addr, bus.mdu_data});
        end else if (e_cnt > 0) begin
          ent  = mq.pop_front();
          e_we = ent.live && (ent.addr != 0); e_a = ent.addr; e_d = ent.data;
          if (xfer) mq.push_back('{1'b1, bus.mdu_addr, bus.mdu_data});
        end else if (xfer) begin
          e_we = (bus.mdu_addr != 0); e_a = bus.mdu_addr; e_d = bus.mdu_data;
        end
        checks++; if (bus.mdu_ready !== e_ready) begin errors++; $display("FAIL rnd_ready c%0d: got %b expected %b", c, bus.mdu_ready, e_ready); end
        checks++; if (bus.q_count !== 3'(e_cnt)) begin errors++; $display("FAIL rnd_qcount c%0d: got %0d expected %0d", c, bus.q_count, e_cnt); end
        checks++; if (bus.pend_mask !== e_pend) begin errors++; $display("FAIL rnd_pend c%0d: got %h expected %h", c, bus.pend_mask, e_pend); end
        checks++; if (bus.WE3 !== e_we) begin errors++; $display("FAIL rnd_we3 c%0d: got %b expected %b", c, bus.WE3, e_we); end
        if (e_we) begin
          checks++; if (bus.A3 !== e_a || bus.WD3 !== e_d) begin errors++;
            $display("FAIL rnd_port c%0d: got a=%0d d=%h expected a=%0d d=%h", c, bus.A3, bus.WD3, e_a, e_d); end
        end
      end
      tick();
    end
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #2;
    test_reset();
    test_direct_mdu();
    test_collision();
    test_full();
    test_kill();
    test_zero_reg();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
